bitblade_operand_loader: RTL and testbench

- Producer side of the column operand interface: accepts a serial 32-bit word stream and assembles one full tile of 16 activation lane words plus 16 weight lane words.
- A tile is presented in parallel to a BitBlade column's packed_input_1..16 and WBUF_data_in_1..16 lanes.
- Double-buffered: a shadow bank fills while the active bank is held for the column; the two banks swap on a tile_valid/tile_ack handshake.

---
 rtl/bitblade_operand_loader.sv | 139 +++++++++++++
 tb/tb_bitblade_operand_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitblade_operand_loader.sv
// Double-buffered operand loader for one BitBlade column.
// Assembles 16 activation words then 16 weight words from a serial stream
// into a shadow bank, and swaps the shadow bank into the active bank on a
// tile_valid/tile_ack handshake.
// Optional build macro: LOADER_PARITY_EN adds s_parity / parity_err and drops
// tiles that received a word with bad even parity.
module bitblade_operand_loader #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [WORD_W-1:0]         s_data,
  input  logic                      flush,
  output logic [LANES*WORD_W-1:0]   packed_input_bus,
  output logic [LANES*WORD_W-1:0]   wbuf_data_bus,
  output logic                      tile_valid,
  input  logic                      tile_ack,
  output logic [CNT_W-1:0]          tile_count
`ifdef LOADER_PARITY_EN
  ,
  input  logic                      s_parity,
  output logic                      parity_err
`endif
);

  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned BUS_W = LANES * WORD_W;

  typedef enum logic [1:0] {
    FILL_X = 2'd0,
    FILL_W = 2'd1,
    FULL   = 2'd2
  } fill_state_e;

  fill_state_e          state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [BUS_W-1:0]     shadow_x_q;
  logic [BUS_W-1:0]     shadow_w_q;
  logic [BUS_W-1:0]     active_x_q;
  logic [BUS_W-1:0]     active_w_q;
  logic                 tile_valid_q;
  logic [CNT_W-1:0]     tile_count_q;

  logic                 xfer;
  logic                 last_lane;
  logic                 tile_bad;
  logic                 word_bad;
  logic                 swap;
  logic                 drop;
  int unsigned          lane_base;

`ifdef LOADER_PARITY_EN
  logic bad_q;
  logic parity_err_q;
  assign tile_bad   = bad_q;
  assign word_bad   = (^s_data) ^ s_parity;
  assign parity_err = parity_err_q;
`else
  assign tile_bad   = 1'b0;
  assign word_bad   = 1'b0;
`endif

  // Ready is a function of state only; held low while reset is asserted.
  assign s_ready   = reset && (state_q != FULL);
  assign xfer      = s_valid && s_ready && !flush;
  assign last_lane = (idx_q == IDX_W'(LANES - 1));
  assign lane_base = 32'(idx_q) * WORD_W;
  assign swap      = (state_q == FULL) && !tile_bad && (!tile_valid_q || tile_ack);
  assign drop      = (state_q == FULL) && tile_bad;

  assign packed_input_bus = active_x_q;
  assign wbuf_data_bus    = active_w_q;
  assign tile_valid       = tile_valid_q;
  assign tile_count       = tile_count_q;

  // Fill FSM, shadow/active banks and handshake; swap beats flush beats transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= FILL_X;
      idx_q        <= '0;
      shadow_x_q   <= '0;
      shadow_w_q   <= '0;
      active_x_q   <= '0;
      active_w_q   <= '0;
      tile_valid_q <= 1'b0;
      tile_count_q <= '0;
`ifdef LOADER_PARITY_EN
      bad_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else if (swap) begin
      active_x_q   <= shadow_x_q;
      active_w_q   <= shadow_w_q;
      tile_valid_q <= 1'b1;
      tile_count_q <= tile_count_q + CNT_W'(1);
      state_q      <= FILL_X;
      idx_q        <= '0;
    end else begin
      if (tile_ack && tile_valid_q) begin
        tile_valid_q <= 1'b0;
      end
      if (drop || flush) begin
        state_q <= FILL_X;
        idx_q   <= '0;
`ifdef LOADER_PARITY_EN
        bad_q   <= 1'b0;
`endif
      end else if (xfer) begin
        if (state_q == FILL_X) begin
          shadow_x_q[lane_base +: WORD_W] <= s_data;
        end else begin
          shadow_w_q[lane_base +: WORD_W] <= s_data;
        end
        if (last_lane) begin
          idx_q   <= '0;
          state_q <= (state_q == FILL_X) ? FILL_W : FULL;
        end else begin
          idx_q   <= idx_q + IDX_W'(1);
        end
`ifdef LOADER_PARITY_EN
        if (word_bad) begin
          bad_q        <= 1'b1;
          parity_err_q <= 1'b1;
        end
`endif
      end
    end
  end

`ifndef LOADER_PARITY_EN
  logic unused_ok;
  assign unused_ok = word_bad;
`endif

endmodule

// File: tb/tb_bitblade_operand_loader.sv
// Self-checking bench for bitblade_operand_loader: a vector table for the
// first tile, directed multi-cycle sequences, and a randomized phase checked
// against a queue-based tile model.
module tb_bitblade_operand_loader;

  localparam int unsigned LANES  = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BUS_W  = LANES * WORD_W;

  logic               clk = 1'b0;
  logic               reset;
  logic               s_valid;
  logic               s_ready;
  logic [WORD_W-1:0]  s_data;
  logic               flush;
  logic [BUS_W-1:0]   packed_input_bus;
  logic [BUS_W-1:0]   wbuf_data_bus;
  logic               tile_valid;
  logic               tile_ack;
  logic [CNT_W-1:0]   tile_count;
`ifdef LOADER_PARITY_EN
  logic               s_parity;
  logic               parity_err;
`endif

  always #5 clk = ~clk;

  bitblade_operand_loader #(.LANES(LANES), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_data           (s_data),
    .flush            (flush),
    .packed_input_bus (packed_input_bus),
    .wbuf_data_bus    (wbuf_data_bus),
    .tile_valid       (tile_valid),
    .tile_ack         (tile_ack),
    .tile_count       (tile_count)
`ifdef LOADER_PARITY_EN
    ,
    .s_parity         (s_parity),
    .parity_err       (parity_err)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: accepted words queue up; 32 queued words form a tile.
  int unsigned        mq[$];
  logic [BUS_W-1:0]   m_x;
  logic [BUS_W-1:0]   m_w;
  bit                 m_tv;
  bit                 m_bad;
  bit                 m_perr;
  int unsigned        m_cnt;

  task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit v, input logic [WORD_W-1:0] d,
                            input bit fl, input bit ak, input bit pbad);
    bit full;
    if (!rst) begin
      mq.delete();
      m_x = '0; m_w = '0; m_tv = 1'b0; m_cnt = 0; m_bad = 1'b0; m_perr = 1'b0;
    end else begin
      full = (mq.size() == 2 * LANES);
      if (full && !m_bad && (!m_tv || ak)) begin
        for (int k = 0; k < LANES; k++) begin
          m_x[k*WORD_W +: WORD_W] = mq[k];
          m_w[k*WORD_W +: WORD_W] = mq[k+LANES];
        end
        m_tv  = 1'b1;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        mq.delete();
      end else begin
        if (ak && m_tv) m_tv = 1'b0;
        if ((full && m_bad) || fl) begin
          mq.delete();
          m_bad = 1'b0;
        end else if (v && !full) begin
          mq.push_back(d);
          if (pbad) begin
            m_bad  = 1'b1;
            m_perr = 1'b1;
          end
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after.
  task automatic cyc(input bit rst, input bit v, input logic [WORD_W-1:0] d,
                     input bit fl, input bit ak, input bit pbad);
    bit eff_pbad;
    reset    = rst;
    s_valid  = v;
    s_data   = d;
    flush    = fl;
    tile_ack = ak;
`ifdef LOADER_PARITY_EN
    s_parity = (^d) ^ pbad;
    eff_pbad = pbad;
`else
    eff_pbad = 1'b0;
`endif
    @(posedge clk);
    model_edge(rst, v, d, fl, ak, eff_pbad);
    #1;
    chk("s_ready",    BUS_W'(s_ready),    BUS_W'(rst && (mq.size() != 2 * LANES)));
    chk("tile_valid", BUS_W'(tile_valid), BUS_W'(m_tv));
    chk("tile_count", BUS_W'(tile_count), BUS_W'(m_cnt));
    chk("packed_bus", packed_input_bus,   m_x);
    chk("wbuf_bus",   wbuf_data_bus,      m_w);
`ifdef LOADER_PARITY_EN
    chk("parity_err", BUS_W'(parity_err), BUS_W'(m_perr));
`endif
  endtask

  task automatic send(input int n, input logic [WORD_W-1:0] base);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, base + WORD_W'(i), 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [WORD_W-1:0] lane(input logic [BUS_W-1:0] bus, input int k);
    return bus[k*WORD_W +: WORD_W];
  endfunction

  typedef struct {
    bit               rst;
    bit               v;
    logic [WORD_W-1:0] d;
    bit               ack;
    bit               exp_ready;
    bit               exp_tv;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t tbl[34];

  initial begin
    reset = 1'b0; s_valid = 1'b0; s_data = '0; flush = 1'b0; tile_ack = 1'b0;
`ifdef LOADER_PARITY_EN
    s_parity = 1'b0;
`endif

    // Reset, then first tile streamed back-to-back, then the swap edge.
    tbl[0] = '{rst: 1'b0, v: 1'b0, d: '0, ack: 1'b0, exp_ready: 1'b0, exp_tv: 1'b0, exp_cnt: '0};
    for (int i = 0; i < 32; i++)
      tbl[i+1] = '{rst: 1'b1, v: 1'b1, d: 32'h1000 + 32'(i), ack: 1'b0,
                   exp_ready: (i < 31), exp_tv: 1'b0, exp_cnt: '0};
    tbl[33] = '{rst: 1'b1, v: 1'b0, d: '0, ack: 1'b0, exp_ready: 1'b1, exp_tv: 1'b1, exp_cnt: 16'd1};

    for (int i = 0; i < 34; i++) begin
      cyc(tbl[i].rst, tbl[i].v, tbl[i].d, 1'b0, tbl[i].ack, 1'b0);
      chk($sformatf("tbl%0d_ready", i), BUS_W'(s_ready),    BUS_W'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_tv", i),    BUS_W'(tile_valid), BUS_W'(tbl[i].exp_tv));
      chk($sformatf("tbl%0d_cnt", i),   BUS_W'(tile_count), BUS_W'(tbl[i].exp_cnt));
    end
    chk("t1_x_lane0",  BUS_W'(lane(packed_input_bus, 0)),  BUS_W'(32'h1000));
    chk("t1_x_lane15", BUS_W'(lane(packed_input_bus, 15)), BUS_W'(32'h100F));
    chk("t1_w_lane0",  BUS_W'(lane(wbuf_data_bus, 0)),     BUS_W'(32'h1010));
    chk("t1_w_lane15", BUS_W'(lane(wbuf_data_bus, 15)),    BUS_W'(32'h101F));

    // Second tile waits in FULL until acked; swap happens with no valid gap.
    send(32, 32'h2000);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t2_full_ready", BUS_W'(s_ready), BUS_W'(1'b0));
    chk("t2_hold_lane0", BUS_W'(lane(packed_input_bus, 0)), BUS_W'(32'h1000));
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("t2_tv",    BUS_W'(tile_valid), BUS_W'(1'b1));
    chk("t2_cnt",   BUS_W'(tile_count), BUS_W'(16'd2));
    chk("t2_lane0", BUS_W'(lane(packed_input_bus, 0)), BUS_W'(32'h2000));

    // Release mid-fill: bus held, then the completed tile swaps without ack.
    send(5, 32'h3000);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("rel_tv",    BUS_W'(tile_valid), BUS_W'(1'b0));
    chk("rel_lane0", BUS_W'(lane(packed_input_bus, 0)), BUS_W'(32'h2000));
    send(27, 32'h3005);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t3_tv",     BUS_W'(tile_valid), BUS_W'(1'b1));
    chk("t3_cnt",    BUS_W'(tile_count), BUS_W'(16'd3));
    chk("t3_w_lane15", BUS_W'(lane(wbuf_data_bus, 15)), BUS_W'(32'h301F));

    // Flush drops 20 partial words and the word presented with it.
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    send(20, 32'hBAD0);
    cyc(1'b1, 1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b0);
    send(32, 32'h00A0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("fl_lane0",    BUS_W'(lane(packed_input_bus, 0)), BUS_W'(32'h00A0));
    chk("fl_w_lane15", BUS_W'(lane(wbuf_data_bus, 15)),   BUS_W'(32'h00BF));
    chk("fl_cnt",      BUS_W'(tile_count), BUS_W'(16'd4));

    // Reset mid FILL_W while a tile is held.
    send(20, 32'h5000);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_tv",    BUS_W'(tile_valid), BUS_W'(1'b0));
    chk("rst_cnt",   BUS_W'(tile_count), BUS_W'(16'd0));
    chk("rst_bus",   packed_input_bus | wbuf_data_bus, '0);
    chk("rst_ready", BUS_W'(s_ready), BUS_W'(1'b0));
    reset = 1'b1;
    #1;
    chk("rel_ready", BUS_W'(s_ready), BUS_W'(1'b1));

`ifdef LOADER_PARITY_EN
    // Bad parity on word 7 drops the tile; the next clean tile is presented.
    for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 32'h7000 + 32'(i), 1'b0, 1'b0, i == 7);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("par_err", BUS_W'(parity_err), BUS_W'(1'b1));
    chk("par_tv",  BUS_W'(tile_valid), BUS_W'(1'b0));
    chk("par_cnt", BUS_W'(tile_count), BUS_W'(16'd0));
    send(32, 32'h8000);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("par2_tv",    BUS_W'(tile_valid), BUS_W'(1'b1));
    chk("par2_cnt",   BUS_W'(tile_count), BUS_W'(16'd1));
    chk("par2_lane0", BUS_W'(lane(packed_input_bus, 0)), BUS_W'(32'h8000));
    chk("par2_err",   BUS_W'(parity_err), BUS_W'(1'b1));
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 499) != 0,
          $urandom_range(0, 9) < 7,
          WORD_W'($urandom),
          $urandom_range(0, 49) == 0,
          $urandom_range(0, 9) < 3,
          $urandom_range(0, 99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
